pc_ctrl: RTL

//  Parametrised program-counter unit for the multicycle MIPS core: word-addressed PC register plus next-PC selection.

---
 rtl/pc_pkg.sv | 11 +
 rtl/pc_ctrl_if.sv | 29 ++
 rtl/pc_ras.sv | 44 ++++
 rtl/pc_ctrl.sv | 81 ++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared encodings and default vectors for the PC unit (RAS via PC_RAS_EN)
package pc_pkg;
  localparam logic [2:0] NPC_SEQ  = 3'd0;
  localparam logic [2:0] NPC_BR   = 3'd1;
  localparam logic [2:0] NPC_J    = 3'd2;
  localparam logic [2:0] NPC_JR   = 3'd3;
  localparam logic [2:0] NPC_ERET = 3'd5;
  typedef enum logic {ST_NORM = 1'b0, ST_EXC = 1'b1} pc_state_t;
  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_4180;
endpackage

// File: rtl/pc_ctrl_if.sv
// pc_ctrl_if: control/datapath bundle of the PC unit; RAS signals exist only with PC_RAS_EN
interface pc_ctrl_if #(parameter int AW = 32);
  logic          pc_wr;
  logic [2:0]    npc_sel;
  logic [15:0]   imm16;
  logic [25:0]   target26;
  logic [AW-1:0] jr_addr;
  logic          exc_req;
  logic [AW-3:0] pc;
  logic [AW-3:0] pc_plus4;
  logic [AW-3:0] epc;
  logic          in_exc;
  logic          addr_err;
`ifdef PC_RAS_EN
  logic          ras_push;
  logic          ras_pop;
  logic [AW-3:0] ras_top;
  logic          ras_miss;
  modport master(output pc_wr, npc_sel, imm16, target26, jr_addr, exc_req, ras_push, ras_pop,
                 input pc, pc_plus4, epc, in_exc, addr_err, ras_top, ras_miss);
  modport slave(input pc_wr, npc_sel, imm16, target26, jr_addr, exc_req, ras_push, ras_pop,
                output pc, pc_plus4, epc, in_exc, addr_err, ras_top, ras_miss);
`else
  modport master(output pc_wr, npc_sel, imm16, target26, jr_addr, exc_req,
                 input pc, pc_plus4, epc, in_exc, addr_err);
  modport slave(input pc_wr, npc_sel, imm16, target26, jr_addr, exc_req,
                output pc, pc_plus4, epc, in_exc, addr_err);
`endif
endinterface

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack (used only with PC_RAS_EN)
module pc_ras #(
  parameter int W     = 30,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] pc1,
  input  logic [W-1:0] jr_word,
  output logic [W-1:0] top,
  output logic         miss
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] ptr, up, dn;
  logic [CW-1:0] cnt;
  assign up  = ptr == PW'(DEPTH - 1) ? '0 : ptr + 1'b1;
  assign dn  = ptr == '0 ? PW'(DEPTH - 1) : ptr - 1'b1;
  assign top = mem[ptr];
  // push overwrites the oldest slot on overflow; push+pop replaces the top in place
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      ptr  <= '0;
      cnt  <= '0;
      miss <= 1'b0;
    end else begin
      miss <= en && pop && (cnt == '0 || mem[ptr] != jr_word);
      if (en && push && pop) mem[ptr] <= pc1;
      else if (en && push) begin
        mem[up] <= pc1;
        ptr     <= up;
        cnt     <= cnt == CW'(DEPTH) ? cnt : cnt + 1'b1;
      end else if (en && pop && cnt != '0) begin
        ptr <= dn;
        cnt <= cnt - 1'b1;
      end
    end
  end
endmodule

// File: rtl/pc_ctrl.sv
// pc_ctrl: word-addressed PC with next-PC mux, EPC and NORM/EXC FSM; optional RAS with PC_RAS_EN
module pc_ctrl
  import pc_pkg::*;
#(
  parameter int            AW        = 32,
  parameter logic [AW-1:0] RESET_VEC = AW'(DEF_RESET_VEC),
  parameter logic [AW-1:0] EXC_VEC   = AW'(DEF_EXC_VEC),
  parameter int            RAS_DEPTH = 4
) (
  input logic      clk,
  input logic      rst,
  pc_ctrl_if.slave bus
);
  localparam int W = AW - 2;
  logic [W-1:0] pc_q, pc_d, epc_q, epc_d, seq, npc;
  pc_state_t    st_q, st_d;
  logic         err_q, mis, eret;
  // next-PC candidates; reserved selects fall through to sequential
  always_comb begin
    seq  = pc_q + 1'b1;
    mis  = bus.pc_wr && bus.npc_sel == NPC_JR && bus.jr_addr[1:0] != 2'b00;
    eret = bus.pc_wr && bus.npc_sel == NPC_ERET;
    npc  = bus.npc_sel == NPC_BR   ? seq + {{(W-16){bus.imm16[15]}}, bus.imm16} :
           bus.npc_sel == NPC_J    ? {pc_q[W-1:26], bus.target26} :
           bus.npc_sel == NPC_JR   ? bus.jr_addr[AW-1:2] :
           bus.npc_sel == NPC_ERET ? epc_q : seq;
  end
  // exception entry beats pc_wr in NORM; in EXC only ERET or a misaligned JR matter specially
  always_comb begin
    st_d  = st_q;
    pc_d  = pc_q;
    epc_d = epc_q;
    if (st_q == ST_NORM) begin
      if (bus.exc_req || mis) begin
        epc_d = pc_q;
        pc_d  = EXC_VEC[AW-1:2];
        st_d  = ST_EXC;
      end else if (bus.pc_wr) pc_d = npc;
    end else begin
      if (eret) begin
        pc_d = epc_q;
        st_d = ST_NORM;
      end else if (mis) pc_d = EXC_VEC[AW-1:2];
      else if (bus.pc_wr) pc_d = npc;
    end
  end
  // state, PC, EPC and the registered misalignment pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q  <= ST_NORM;
      pc_q  <= RESET_VEC[AW-1:2];
      epc_q <= '0;
      err_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      pc_q  <= pc_d;
      epc_q <= epc_d;
      err_q <= mis;
    end
  end
  assign bus.pc       = pc_q;
  assign bus.pc_plus4 = seq;
  assign bus.epc      = epc_q;
  assign bus.in_exc   = st_q == ST_EXC;
  assign bus.addr_err = err_q;
`ifdef PC_RAS_EN
  logic ras_en;
  assign ras_en = bus.pc_wr && !mis && !(st_q == ST_NORM && bus.exc_req);
  pc_ras #(.W(W), .DEPTH(RAS_DEPTH)) u_ras (
    .clk    (clk),
    .rst    (rst),
    .en     (ras_en),
    .push   (bus.ras_push),
    .pop    (bus.ras_pop),
    .pc1    (seq),
    .jr_word(bus.jr_addr[AW-1:2]),
    .top    (bus.ras_top),
    .miss   (bus.ras_miss)
  );
`endif
endmodule
